// File: rtl/stoch_bitstream_gen_pkg.sv
// Shared definitions for the stochastic bitstream generator: FSM encoding,
// maximal-length LFSR tap masks for widths 4..16, and a ceil(log2) helper.
// No logic of its own; no latency or flow control.
package stoch_bitstream_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Tap masks for a left-shifting Fibonacci LFSR: mask bit (t-1) is set for
  // each polynomial term x^t. Every entry is a primitive polynomial.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] m;
    case (w)
      4:       m = 16'h000C;  // x^4+x^3+1
      5:       m = 16'h0014;  // x^5+x^3+1
      6:       m = 16'h0030;  // x^6+x^5+1
      7:       m = 16'h0060;  // x^7+x^6+1
      8:       m = 16'h00B8;  // x^8+x^6+x^5+x^4+1
      9:       m = 16'h0110;  // x^9+x^5+1
      10:      m = 16'h0240;  // x^10+x^7+1
      11:      m = 16'h0500;  // x^11+x^9+1
      12:      m = 16'h0829;  // x^12+x^6+x^4+x+1
      13:      m = 16'h100D;  // x^13+x^4+x^3+x+1
      14:      m = 16'h2015;  // x^14+x^5+x^3+x+1
      15:      m = 16'h6000;  // x^15+x^14+1
      16:      m = 16'hD008;  // x^16+x^15+x^13+x^4+1
      default: m = 16'h00B8;
    endcase
    return m;
  endfunction

  // Smallest r with 2^r >= n (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_w.sv
// Maximal-length Fibonacci LFSR of width W; shifts left, feedback into bit 0.
// Latency: STATE updates on the clock edge where LOAD or EN is high.
// No backpressure; RESET and LOAD both force SEED, RESET taking priority.
module lfsr_w
  import stoch_bitstream_gen_pkg::*;
#(
  parameter int W    = 8,  // register width, 4..16
  parameter int SEED = 1   // nonzero load value below 2^W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         LOAD,
  input  logic         EN,
  output logic [W-1:0] STATE
);

  localparam logic [W-1:0] MASK   = W'(lfsr_taps(W));
  localparam logic [W-1:0] SEED_V = W'(SEED);

  logic [W-1:0] r_state;
  logic         w_fb;

  assign w_fb  = ^(r_state & MASK);
  assign STATE = r_state;

  // Seed on reset or load, otherwise step one position when enabled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= SEED_V;
    end else if (LOAD) begin
      r_state <= SEED_V;
    end else if (EN) begin
      r_state <= {r_state[W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/stoch_bitstream_gen.sv
// Emits an L-bit stochastic stream, bit = (LFSR < VALUE), one bit per cycle.
// Latency: first bit one cycle after START is accepted; DONE one cycle after bit L.
// No backpressure: START is ignored while BUSY; downstream must take every bit.
module stoch_bitstream_gen
  import stoch_bitstream_gen_pkg::*;
#(
  parameter int W    = 8,    // operand and LFSR width, 4..16
  parameter int L    = 255,  // stream length in bits, 1..65535
  parameter int SEED = 1     // LFSR load value, nonzero and below 2^W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [W-1:0]             VALUE,
  output logic                     BUSY,
  output logic                     BIT_OUT,
  output logic                     BIT_VALID,
  output logic                     DONE,
  output logic [clog2(L+1)-1:0]    ONES_CNT
);

  localparam int            CW     = clog2(L + 1);
  localparam logic [W-1:0]  SEED_V = W'(SEED);
  localparam logic [CW-1:0] L_V    = CW'(L);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_value;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] r_ones_cnt;
  logic          r_bit;
  logic          r_bit_vld;

  logic          w_accept;
  logic          w_emit;
  logic          w_lfsr_load;
  logic [W-1:0]  w_lfsr;
  logic [W-1:0]  w_cmp_val;
  logic [W-1:0]  w_cmp_ref;
  logic          w_bit_nxt;

  // The LFSR sits at SEED whenever IDLE (reset or reload in FLUSH) and steps
  // on every cycle that emits a bit, so it always holds the next operand.
  lfsr_w #(
    .W    (W),
    .SEED (SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (w_lfsr_load),
    .EN    (w_emit),
    .STATE (w_lfsr)
  );

  // On the accepting edge VALUE has not been latched yet, so compare the
  // live input against SEED; afterwards use the latched value.
  assign w_cmp_val = w_accept ? SEED_V : w_lfsr;
  assign w_cmp_ref = w_accept ? VALUE : r_value;
  assign w_bit_nxt = (w_cmp_val < w_cmp_ref);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_lfsr_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_accept    = 1'b1;
          w_emit      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_bit_cnt == L_V) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_emit = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_lfsr_load = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output bit, bit counter, ones counter and latched probability.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_value    <= '0;
      r_bit      <= 1'b0;
      r_bit_vld  <= 1'b0;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_value <= VALUE;
      end
      if (w_emit) begin
        r_bit      <= w_bit_nxt;
        r_bit_vld  <= 1'b1;
        r_bit_cnt  <= w_accept ? CW'(1) : r_bit_cnt + CW'(1);
        r_ones_cnt <= (w_accept ? '0 : r_ones_cnt) + CW'(w_bit_nxt);
      end else begin
        r_bit     <= 1'b0;
        r_bit_vld <= 1'b0;
      end
    end
  end

  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = (r_state == ST_FLUSH);
  assign BIT_OUT   = r_bit;
  assign BIT_VALID = r_bit_vld;
  assign ONES_CNT  = r_ones_cnt;

endmodule

// File: tb/tb_stoch_bitstream_gen.sv
// Bench for stoch_bitstream_gen: table-driven and random streams against a
// reference LFSR sequence, plus reset, re-start, back-to-back and L=3 cases.
// Drives and samples on the falling edge.
module tb_stoch_bitstream_gen;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [7:0] VALUE = 8'd0;
  logic       BUSY, BIT_OUT, BIT_VALID, DONE;
  logic [7:0] ONES_CNT;

  logic       START3 = 1'b0;
  logic [7:0] VALUE3 = 8'd0;
  logic       BUSY3, BIT_OUT3, BIT_VALID3, DONE3;
  logic [1:0] ONES_CNT3;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] lfsr_seq [0:254];
  logic [7:0] sreg = 8'd0;

  typedef struct {
    logic [7:0] value;
    int         exp_ones;
    bit         repulse;
  } vec_t;

  vec_t tbl [7];

  always #5 CLK = ~CLK;

  // Downstream 8-bit shift register fed by BIT_OUT.
  always @(posedge CLK) sreg <= {sreg[6:0], BIT_OUT};

  stoch_bitstream_gen #(.W(8), .L(255), .SEED(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .START(START), .VALUE(VALUE),
    .BUSY(BUSY), .BIT_OUT(BIT_OUT), .BIT_VALID(BIT_VALID),
    .DONE(DONE), .ONES_CNT(ONES_CNT)
  );

  stoch_bitstream_gen #(.W(8), .L(3), .SEED(1)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .START(START3), .VALUE(VALUE3),
    .BUSY(BUSY3), .BIT_OUT(BIT_OUT3), .BIT_VALID(BIT_VALID3),
    .DONE(DONE3), .ONES_CNT(ONES_CNT3)
  );

  task automatic chk_b(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_ones(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 255; i++) if (lfsr_seq[i] < v) n++;
    return n;
  endfunction

  // Launch one stream from an IDLE falling edge and check it to the end.
  task automatic run_stream(input logic [7:0] v, input int exp_ones,
                            input bit repulse, input string nm);
    int   bit_err = 0;
    int   ones_err = 0;
    int   busy_err = 0;
    int   vld_n = 0;
    int   done_cyc = -1;
    int   ones_run = 0;
    logic exp_b;
    START = 1'b1;
    VALUE = v;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(negedge CLK);
      START = repulse && (cyc == 10 || cyc == 200);
      VALUE = repulse ? 8'd0 : 8'($urandom);
      if (BUSY !== 1'b1) busy_err++;
      if (DONE === 1'b1) begin
        done_cyc = cyc;
        chk_b({nm, "_valid_at_done"}, BIT_VALID, 1'b0);
        chk_b({nm, "_bit_at_done"}, BIT_OUT, 1'b0);
        chk_i({nm, "_ones_at_done"}, 32'(ONES_CNT), exp_ones);
        if (repulse) START = 1'b1;
      end else if (BIT_VALID === 1'b1) begin
        exp_b = (lfsr_seq[vld_n % 255] < v);
        if (BIT_OUT !== exp_b) bit_err++;
        if (exp_b) ones_run++;
        if (ONES_CNT !== 8'(ones_run)) ones_err++;
        vld_n++;
      end
    end
    chk_i({nm, "_done_cycle"}, done_cyc, 256);
    chk_i({nm, "_valid_cycles"}, vld_n, 255);
    chk_i({nm, "_bit_errors"}, bit_err, 0);
    chk_i({nm, "_ones_track_errors"}, ones_err, 0);
    chk_i({nm, "_busy_gaps"}, busy_err, 0);
    @(negedge CLK);
    START = 1'b0;
    chk_b({nm, "_busy_after"}, BUSY, 1'b0);
    chk_i({nm, "_ones_hold"}, 32'(ONES_CNT), exp_ones);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] v;
    int         vld_err;
    int         done_err;
    bit         exp_v;
    bit         exp_d;
    bit [5:1]   ev3;
    bit [5:1]   eb3;
    bit [5:1]   ed3;

    // Expected ones for a full-period stream: every LFSR value 1..v-1 once.
    tbl[0] = '{value: 8'd0,   exp_ones: 0,   repulse: 1'b0};
    tbl[1] = '{value: 8'd1,   exp_ones: 0,   repulse: 1'b0};
    tbl[2] = '{value: 8'd2,   exp_ones: 1,   repulse: 1'b0};
    tbl[3] = '{value: 8'd128, exp_ones: 127, repulse: 1'b0};
    tbl[4] = '{value: 8'd200, exp_ones: 199, repulse: 1'b0};
    tbl[5] = '{value: 8'd255, exp_ones: 254, repulse: 1'b0};
    tbl[6] = '{value: 8'd128, exp_ones: 127, repulse: 1'b1};

    // Reference sequence from x^8+x^6+x^5+x^4+1 starting at SEED=1.
    s = 8'd1;
    for (int i = 0; i < 255; i++) begin
      lfsr_seq[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end

    // Reset dominates a held START.
    START = 1'b1;
    VALUE = 8'd200;
    repeat (3) @(negedge CLK);
    chk_b("rst_busy", BUSY, 1'b0);
    chk_b("rst_valid", BIT_VALID, 1'b0);
    chk_b("rst_bit", BIT_OUT, 1'b0);
    chk_b("rst_done", DONE, 1'b0);
    chk_i("rst_ones", 32'(ONES_CNT), 0);
    chk_b("rst_busy3", BUSY3, 1'b0);
    START = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 7; i++)
      run_stream(tbl[i].value, tbl[i].exp_ones, tbl[i].repulse, $sformatf("tbl%0d", i));

    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      run_stream(v, model_ones(v), 1'b0, $sformatf("rnd%0d_v%0d", i, v));
    end

    // Reset at bit 100, then restart on the first edge after release.
    START = 1'b1;
    VALUE = 8'd128;
    @(negedge CLK);
    START = 1'b0;
    repeat (99) @(negedge CLK);
    chk_b("midrst_busy_before", BUSY, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    chk_b("midrst_busy", BUSY, 1'b0);
    chk_b("midrst_valid", BIT_VALID, 1'b0);
    chk_b("midrst_done", DONE, 1'b0);
    chk_i("midrst_ones", 32'(ONES_CNT), 0);
    RESET = 1'b0;
    run_stream(8'd128, 127, 1'b0, "post_reset");

    // START held: two streams separated by one FLUSH and one IDLE cycle.
    START = 1'b1;
    VALUE = 8'd0;
    vld_err = 0;
    done_err = 0;
    for (int c = 1; c <= 515; c++) begin
      @(negedge CLK);
      exp_v = (c >= 1 && c <= 255) || (c >= 258 && c <= 512);
      exp_d = (c == 256) || (c == 513);
      if (BIT_VALID !== exp_v) vld_err++;
      if (DONE !== exp_d) done_err++;
      if (c == 257) begin
        chk_i("b2b_shift_reg", 32'(sreg), 0);
        chk_b("b2b_idle_gap", BUSY, 1'b0);
      end
      if (c == 300) START = 1'b0;
    end
    chk_i("b2b_valid_pattern_errors", vld_err, 0);
    chk_i("b2b_done_pattern_errors", done_err, 0);

    // L=3, VALUE=2: operands 1,2,4 give bits 1,0,0 and DONE on cycle 4.
    ev3 = 5'b00111;
    eb3 = 5'b00001;
    ed3 = 5'b01000;
    START3 = 1'b1;
    VALUE3 = 8'd2;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      START3 = 1'b0;
      chk_b($sformatf("l3_valid_c%0d", c), BIT_VALID3, ev3[c]);
      chk_b($sformatf("l3_bit_c%0d", c), BIT_OUT3, eb3[c]);
      chk_b($sformatf("l3_done_c%0d", c), DONE3, ed3[c]);
      if (c == 4) chk_i("l3_ones", 32'(ONES_CNT3), 1);
      if (c == 5) chk_b("l3_busy_end", BUSY3, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
